// File: rtl/gray_rd_pkg.sv
// Shared types and frame geometry for the gray-image BRAM stream reader.
package gray_rd_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE_ST} rd_state_t;

    localparam int FRAME_W        = 320;
    localparam int FRAME_H        = 240;
    localparam int NUM_PIXELS_DEF = FRAME_W * FRAME_H;

endpackage

// File: rtl/gray_rd_fifo.sv
// Small first-word fall-through FIFO with occupancy count.
// A word written while the FIFO is empty is presented on the output in the
// same cycle; if it is also accepted that cycle it is never stored.
module gray_rd_fifo
    import gray_rd_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty;
    logic              store;
    logic              pop_mem;

    // Head selection, bypass decision and pointer/count next state.
    always_comb begin
        empty   = (cnt_q == '0);
        valid_o = !empty || wr_en_i;
        if (!empty)
            data_o = mem_q[rd_ptr_q];
        else if (wr_en_i)
            data_o = wr_data_i;
        else
            data_o = '0;
        store    = wr_en_i && !(empty && rd_en_i);
        pop_mem  = !empty && rd_en_i;
        wr_ptr_d = wr_ptr_q + PTR_W'(store);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_mem);
        cnt_d    = cnt_q + CNT_W'(store) - CNT_W'(pop_mem);
    end

    // Storage array; contents need no reset since the output is gated by count.
    always_ff @(posedge clk_i) begin
        if (store)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/gray_bram_stream_reader.sv
// Gray BRAM read master: streams one frame of pixels out as valid/ready/last.
// Requests are credit-limited so that buffered plus in-flight words never
// exceed the output FIFO depth. Optional READBACK_CHECKSUM_EN adds a 32-bit
// running sum of transferred pixels on o_CHECKSUM.
module gray_bram_stream_reader
    import gray_rd_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_START,
    output logic              o_RD_REQ,
    output logic [ADDR_W-1:0] o_RD_ADDR,
    input  logic [DATA_W-1:0] i_RD_DATA,
    output logic [DATA_W-1:0] o_M_DATA,
    output logic              o_M_VALID,
    input  logic              i_M_READY,
    output logic              o_M_LAST,
    output logic              o_BUSY,
    output logic              o_DONE
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [31:0]       o_CHECKSUM
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic [RD_LAT:1]   vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [OCC_W-1:0]  occ;
    logic              rd_req;
    logic              xfer;
    logic              last_xfer;

    // Credit check: room must remain for one more word after buffered + in-flight.
    always_comb begin
        occ = OCC_W'(fifo_cnt);
        for (int i = 1; i <= RD_LAT; i++)
            occ = occ + OCC_W'(vld_pipe_q[i]);
        rd_req = (state_q == READ) && (occ < OCC_W'(FIFO_DEPTH));
    end

    // In-flight tracking: one valid bit per BRAM latency stage.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[1] = rd_req;
        for (int i = 2; i <= RD_LAT; i++)
            vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    assign xfer      = o_M_VALID && i_M_READY;
    assign last_xfer = xfer && (out_cnt_q == LAST_IDX);

    // Frame sequencing, address counter and output pixel counter.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_START) begin
                    state_d   = READ;
                    addr_d    = '0;
                    out_cnt_d = '0;
                end
            end
            READ: begin
                if (rd_req) begin
                    if (addr_q == LAST_IDX)
                        state_d = DRAIN;
                    else
                        addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (last_xfer)
                    state_d = DONE_ST;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer && (out_cnt_q != LAST_IDX))
            out_cnt_d = out_cnt_q + ADDR_W'(1);
    end

    // Control state registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            out_cnt_q  <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            out_cnt_q  <= out_cnt_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    gray_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .wr_en_i   (vld_pipe_q[RD_LAT]),
        .wr_data_i (i_RD_DATA),
        .rd_en_i   (i_M_READY),
        .valid_o   (o_M_VALID),
        .data_o    (o_M_DATA),
        .count_o   (fifo_cnt)
    );

    assign o_RD_REQ  = rd_req;
    assign o_RD_ADDR = addr_q;
    assign o_M_LAST  = o_M_VALID && (out_cnt_q == LAST_IDX);
    assign o_BUSY    = (state_q == READ) || (state_q == DRAIN);
    assign o_DONE    = (state_q == DONE_ST);

`ifdef READBACK_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // Running sum of accepted pixels, cleared when a frame is started.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && i_START)
            csum_d = '0;
        else if (xfer)
            csum_d = csum_q + 32'(o_M_DATA);
    end

    // Checksum accumulator register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            csum_q <= '0;
        else
            csum_q <= csum_d;
    end

    assign o_CHECKSUM = csum_q;
`endif

endmodule

// File: tb/tb_gray_bram_stream_reader.sv
// Bench for gray_bram_stream_reader: two instances (RD_LAT=1 with a 768-pixel
// frame, RD_LAT=3 with a 16-pixel frame), BRAM models returning addr[7:0],
// a per-cycle reference model of the pixel stream, and directed scenarios.
module tb_gray_bram_stream_reader;

    localparam int NP_A  = 768;
    localparam int NP_B  = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start   [2];
    logic        ready   [2];
    logic        rd_req  [2];
    logic [16:0] rd_addr [2];
    logic [7:0]  m_data  [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        busy    [2];
    logic        done    [2];
    logic [7:0]  bram_a;
    logic [7:0]  bram_b  [3];
`ifdef READBACK_CHECKSUM_EN
    logic [31:0] csum    [2];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_bram_stream_reader #(.NUM_PIXELS(NP_A), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_START(start[0]),
        .o_RD_REQ(rd_req[0]), .o_RD_ADDR(rd_addr[0]), .i_RD_DATA(bram_a),
        .o_M_DATA(m_data[0]), .o_M_VALID(m_valid[0]), .i_M_READY(ready[0]),
        .o_M_LAST(m_last[0]), .o_BUSY(busy[0]), .o_DONE(done[0])
`ifdef READBACK_CHECKSUM_EN
        , .o_CHECKSUM(csum[0])
`endif
    );

    gray_bram_stream_reader #(.NUM_PIXELS(NP_B), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_START(start[1]),
        .o_RD_REQ(rd_req[1]), .o_RD_ADDR(rd_addr[1]), .i_RD_DATA(bram_b[2]),
        .o_M_DATA(m_data[1]), .o_M_VALID(m_valid[1]), .i_M_READY(ready[1]),
        .o_M_LAST(m_last[1]), .o_BUSY(busy[1]), .o_DONE(done[1])
`ifdef READBACK_CHECKSUM_EN
        , .o_CHECKSUM(csum[1])
`endif
    );

    // BRAM models: data = addr[7:0]; junk on cycles with no request.
    always @(posedge clk) begin
        bram_a    <= rd_req[0] ? rd_addr[0][7:0] : 8'hEE;
        bram_b[0] <= rd_req[1] ? rd_addr[1][7:0] : 8'hEE;
        bram_b[1] <= bram_b[0];
        bram_b[2] <= bram_b[1];
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int np(input int i);
        return (i == 0) ? NP_A : NP_B;
    endfunction

    // Reference model state: frame progress in plain counts.
    int         req_n  [2] = '{0, 0};
    int         xfer_n [2] = '{0, 0};
    int         done_n [2] = '{0, 0};
    bit         busy_e [2] = '{0, 0};
    bit         idle_e [2] = '{1, 1};
    bit         stall_p[2] = '{0, 0};
    bit         lastx_p[2] = '{0, 0};
    logic [7:0] data_p [2];
    logic [7:0] last_data [2];

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit idle_now, lastx_old, xf, lastx_now;
            if (rst) begin
                chk(!rd_req[i] && rd_addr[i] == 0 && !m_valid[i] && !m_last[i] &&
                    m_data[i] == 0 && !busy[i] && !done[i], "reset_outputs",
                    longint'({rd_addr[i], m_data[i], rd_req[i], m_valid[i], m_last[i], busy[i], done[i]}), 0);
                req_n[i] = 0; xfer_n[i] = 0; busy_e[i] = 0; idle_e[i] = 1;
                stall_p[i] = 0; lastx_p[i] = 0;
            end else begin
                idle_now  = idle_e[i];
                lastx_old = lastx_p[i];
                chk(busy[i] == busy_e[i], "busy", busy[i], busy_e[i]);
                chk(done[i] == lastx_old, "done", done[i], lastx_old);
                if (done[i]) done_n[i]++;
                if (rd_req[i])
                    chk(busy_e[i] && req_n[i] < np(i) && rd_addr[i] == 17'(req_n[i]),
                        "rd_addr", rd_addr[i], req_n[i]);
                chk(req_n[i] + int'(rd_req[i]) - xfer_n[i] <= DEPTH, "outstanding",
                    req_n[i] + int'(rd_req[i]) - xfer_n[i], DEPTH);
                if (m_valid[i]) begin
                    chk(xfer_n[i] < req_n[i] && m_data[i] == 8'(xfer_n[i]), "m_data",
                        m_data[i], xfer_n[i] % 256);
                    chk(m_last[i] == (xfer_n[i] == np(i) - 1), "m_last",
                        m_last[i], xfer_n[i] == np(i) - 1);
                end else begin
                    chk(!m_last[i], "last_without_valid", m_last[i], 0);
                end
                if (stall_p[i])
                    chk(m_valid[i] && m_data[i] == data_p[i], "stall_hold", m_data[i], data_p[i]);
                xf         = m_valid[i] && ready[i];
                lastx_now  = xf && (xfer_n[i] == np(i) - 1);
                stall_p[i] = m_valid[i] && !ready[i];
                data_p[i]  = m_data[i];
                if (xf) begin
                    if (lastx_now) last_data[i] = m_data[i];
                    xfer_n[i]++;
                end
                if (rd_req[i]) req_n[i]++;
                if (lastx_old) idle_e[i] = 1;
                lastx_p[i] = lastx_now;
                if (lastx_now) busy_e[i] = 0;
                if (start[i] && idle_now) begin
                    busy_e[i] = 1; idle_e[i] = 0; req_n[i] = 0; xfer_n[i] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    // Run until one DONE pulse; ready driven at 'duty' percent.
    task automatic run_to_done(input int i, input int duty, input int budget);
        int d0;
        int n;
        d0 = done_n[i];
        n  = 0;
        while (done_n[i] == d0 && n < budget) begin
            ready[i] = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            step();
            n++;
        end
        chk(done_n[i] != d0, "done_timeout", n, budget);
        ready[i] = 1'b1;
        repeat (3) step();
        chk(done_n[i] - d0 == 1, "done_once", done_n[i] - d0, 1);
        chk(xfer_n[i] == np(i), "pixel_count", xfer_n[i], np(i));
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        ready[0] = 1'b1; ready[1] = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Test 1: full-rate frame, latency and last pixel.
        pulse_start(0);
        chk(rd_req[0] && rd_addr[0] == 0 && !m_valid[0], "t1_first_req", rd_addr[0], 0);
        step();
        chk(m_valid[0] && m_data[0] == 8'h00, "t1_latency", m_valid[0], 1);
        run_to_done(0, 100, 2000);
        chk(last_data[0] == 8'hFF, "t1_last_pixel", last_data[0], 255);
`ifdef READBACK_CHECKSUM_EN
        chk(csum[0] == 32'd97920, "t1_checksum", csum[0], 97920);
`endif

        // Test 2: 30% ready duty, stream must be identical.
        pulse_start(0);
        run_to_done(0, 30, 8000);
        chk(last_data[0] == 8'hFF, "t2_last_pixel", last_data[0], 255);

        // Test 3: downstream stalled, only FIFO_DEPTH requests issue.
        ready[0] = 1'b0;
        pulse_start(0);
        cnt = 0;
        repeat (100) begin
            if (rd_req[0]) cnt++;
            step();
        end
        chk(cnt == DEPTH, "t3_req_count", cnt, DEPTH);
        chk(m_valid[0] && m_data[0] == 8'h00, "t3_head_held", m_data[0], 0);
        ready[0] = 1'b1;
        step();
        chk(rd_req[0] && rd_addr[0] == 17'd4, "t3_resume", rd_addr[0], 4);
        run_to_done(0, 100, 2000);

        // Test 4: RD_LAT=3, 16-pixel frame.
        pulse_start(1);
        step(); step();
        chk(!m_valid[1], "t4_not_early", m_valid[1], 0);
        step();
        chk(m_valid[1] && m_data[1] == 8'h00, "t4_latency", m_valid[1], 1);
        run_to_done(1, 100, 200);
        chk(last_data[1] == 8'h0F, "t4_last_pixel", last_data[1], 15);
        pulse_start(1);
        run_to_done(1, 50, 400);

        // Test 5: reset mid-frame, no DONE, restart from address 0.
        pulse_start(0);
        cnt = 0;
        while (xfer_n[0] < 300 && cnt < 1000) begin
            step();
            cnt++;
        end
        chk(xfer_n[0] >= 300, "t5_reach_300", xfer_n[0], 300);
        rst = 1'b1;
        step();
        chk(!busy[0] && !m_valid[0] && !rd_req[0] && !done[0], "t5_reset_outputs",
            longint'({busy[0], m_valid[0], rd_req[0], done[0]}), 0);
        step();
        rst = 1'b0;
        cnt = done_n[0];
        repeat (10) step();
        chk(done_n[0] == cnt, "t5_no_done", done_n[0], cnt);
        pulse_start(0);
        chk(rd_req[0] && rd_addr[0] == 0, "t5_restart_addr", rd_addr[0], 0);
        run_to_done(0, 100, 2000);

        // Test 6: start pulsed mid-READ is ignored.
        pulse_start(0);
        repeat (50) step();
        pulse_start(0);
        run_to_done(0, 100, 2000);
`ifdef READBACK_CHECKSUM_EN
        chk(csum[0] == 32'd97920, "t6_checksum", csum[0], 97920);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
